// File: rtl/intt_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly: out0 = (a+b) mod q, out1 = ((a-b) mod q * zeta) mod q,
// with optional mod-q halving of both results; 3-stage pipeline with a global stall.
module intt_butterfly #(
   parameter int unsigned BIT_LEN = 23,
   parameter int unsigned q       = 8380417
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BIT_LEN-1:0] in0,
   input  logic [BIT_LEN-1:0] in1,
   input  logic [BIT_LEN-1:0] zeta,
   input  logic               half_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BIT_LEN-1:0] out0,
   output logic [BIT_LEN-1:0] out1
);

   localparam logic [BIT_LEN-1:0]   Q_N = BIT_LEN'(q);
   localparam logic [BIT_LEN:0]     Q_E = (BIT_LEN+1)'(q);
   localparam logic [2*BIT_LEN-1:0] Q_W = (2*BIT_LEN)'(q);

   logic                 r_s1_valid;
   logic [BIT_LEN-1:0]   r_s1_sum;
   logic [BIT_LEN-1:0]   r_s1_diff;
   logic [BIT_LEN-1:0]   r_s1_zeta;
   logic                 r_s1_half;

   logic                 r_s2_valid;
   logic [BIT_LEN-1:0]   r_s2_sum;
   logic                 r_s2_half;
   logic [2*BIT_LEN-1:0] r_s2_prod;

   logic                 r_out_valid;
   logic [BIT_LEN-1:0]   r_out0;
   logic [BIT_LEN-1:0]   r_out1;

   logic                 w_stall;
   logic [BIT_LEN:0]     w_sum_raw;
   logic [BIT_LEN:0]     w_sum_red;
   logic [BIT_LEN-1:0]   w_sum;
   logic [BIT_LEN-1:0]   w_diff;
   logic [BIT_LEN-1:0]   w_pmod;
   logic [BIT_LEN-1:0]   w_out0;
   logic [BIT_LEN-1:0]   w_out1;

   // Division by two mod q: odd values borrow one q so the shift stays exact.
   function automatic logic [BIT_LEN-1:0] halve(input logic [BIT_LEN-1:0] x);
      logic [BIT_LEN:0] t;
      t = x[0] ? ({1'b0, x} + Q_E) : {1'b0, x};
      return BIT_LEN'(t >> 1);
   endfunction

   assign w_stall   = r_out_valid & ~out_ready;
   assign in_ready  = reset & ~w_stall;

   assign w_sum_raw = {1'b0, in0} + {1'b0, in1};
   assign w_sum_red = (w_sum_raw >= Q_E) ? (w_sum_raw - Q_E) : w_sum_raw;
   assign w_sum     = BIT_LEN'(w_sum_red);
   assign w_diff    = (in0 >= in1) ? (in0 - in1) : (in0 + Q_N - in1);

   assign w_pmod    = BIT_LEN'(r_s2_prod % Q_W);
   assign w_out0    = r_s2_half ? halve(r_s2_sum) : r_s2_sum;
   assign w_out1    = r_s2_half ? halve(w_pmod)   : w_pmod;

   // All stages advance together; a stalled output freezes the whole pipe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_sum    <= '0;
         r_s1_diff   <= '0;
         r_s1_zeta   <= '0;
         r_s1_half   <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_s2_sum    <= '0;
         r_s2_half   <= 1'b0;
         r_s2_prod   <= '0;
         r_out_valid <= 1'b0;
         r_out0      <= '0;
         r_out1      <= '0;
      end else if (!w_stall) begin
         r_s1_valid  <= in_valid;
         r_s1_sum    <= w_sum;
         r_s1_diff   <= w_diff;
         r_s1_zeta   <= zeta;
         r_s1_half   <= half_en;
         r_s2_valid  <= r_s1_valid;
         r_s2_sum    <= r_s1_sum;
         r_s2_half   <= r_s1_half;
         r_s2_prod   <= r_s1_diff * r_s1_zeta;
         r_out_valid <= r_s2_valid;
         r_out0      <= w_out0;
         r_out1      <= w_out1;
      end
   end

   assign out_valid = r_out_valid;
   assign out0      = r_out0;
   assign out1      = r_out1;

endmodule
